// File: rtl/beat_packer_pkg.sv
// Shared types for the beat packer: the holding-register occupancy state.
package beat_packer_pkg;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/beat_packer.sv
// Packs RATIO narrow beats (or fewer, closed early by in_last) into one wide
// word, held in a single output register that pushes into a downstream fifo.
module beat_packer
  import beat_packer_pkg::*;
#(
  parameter int unsigned IN_DW = 32,
  parameter int unsigned RATIO = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_flush,
  input  logic [IN_DW-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [IN_DW*RATIO-1:0] push_data,
  output logic [RATIO-1:0]       push_mask,
  output logic                   push,
  input  logic                   ready
);

  localparam int unsigned OUT_DW = IN_DW * RATIO;
  localparam int unsigned IDX_W  = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  hold_state_e        hold_state_q, hold_state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_DW-1:0]  acc_q, acc_d;
  logic [RATIO-1:0]   mask_q, mask_d;
  logic [OUT_DW-1:0]  hold_data_q, hold_data_d;
  logic [RATIO-1:0]   hold_mask_q, hold_mask_d;

  logic               accept;
  logic               complete;
  logic [OUT_DW-1:0]  acc_merged;
  logic [RATIO-1:0]   mask_merged;

  // Holding-register state register
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_state_q <= HOLD_EMPTY;
    end else begin
      hold_state_q <= hold_state_d;
    end
  end

  // A completing beat in a push cycle reloads the holder, so FULL persists
  always_comb begin
    hold_state_d = hold_state_q;
    if (valid_flush) begin
      hold_state_d = HOLD_EMPTY;
    end else if (complete) begin
      hold_state_d = HOLD_FULL;
    end else if (push) begin
      hold_state_d = HOLD_EMPTY;
    end
  end

  always_comb begin
    in_ready  = (hold_state_q == HOLD_EMPTY) | ready;
    push      = (hold_state_q == HOLD_FULL) & ready & ~valid_flush;
    push_data = hold_data_q;
    push_mask = hold_mask_q;
  end

  always_comb begin
    accept   = in_valid & in_ready & ~valid_flush;
    complete = accept & ((idx_q == LAST_IDX) | in_last);
  end

  // Accumulator contents as they would be with the current beat written in
  always_comb begin
    acc_merged  = acc_q;
    mask_merged = mask_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (idx_q == IDX_W'(k)) begin
        acc_merged[k*IN_DW +: IN_DW] = in_data;
        mask_merged[k]               = 1'b1;
      end
    end
  end

  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    if (valid_flush) begin
      idx_d  = '0;
      acc_d  = '0;
      mask_d = '0;
    end else if (complete) begin
      hold_data_d = acc_merged;
      hold_mask_d = mask_merged;
      idx_d       = '0;
      acc_d       = '0;
      mask_d      = '0;
    end else if (accept) begin
      acc_d  = acc_merged;
      mask_d = mask_merged;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// Scoreboard bench for beat_packer with IN_DW=32, RATIO=2.
module tb_beat_packer;

  localparam int unsigned IN_DW = 32;
  localparam int unsigned RATIO = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  mask;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] push_data;
  logic [1:0]  push_mask;
  logic        push;
  logic        ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned push_cnt = 0;
  int unsigned run      = 0;
  int unsigned last_run = 0;

  word_t       sb_q[$];
  logic [63:0] m_acc  = '0;
  logic [1:0]  m_mask = '0;
  int unsigned m_idx  = 0;

  beat_packer #(.IN_DW(IN_DW), .RATIO(RATIO)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_flush(valid_flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .push_data  (push_data),
    .push_mask  (push_mask),
    .push       (push),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc  = '0;
    m_mask = '0;
    m_idx  = 0;
  endtask

  // Offer one beat for one cycle; the caller guarantees in_ready is expected high.
  task automatic send_beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    check_eq("in_ready_on_send", in_ready, 1);
    m_acc[m_idx*32 +: 32] = d;
    m_mask[m_idx] = 1'b1;
    if (last || m_idx == RATIO - 1) begin
      sb_q.push_back('{data: m_acc, mask: m_mask});
      model_clear();
    end else begin
      m_idx++;
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_flush(input logic offer);
    valid_flush = 1'b1;
    in_valid    = offer;
    in_data     = 32'h99;
    @(negedge clk);
    check_eq("in_ready_in_flush", in_ready, 1);
    step();
    valid_flush = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    model_clear();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      run = 0;
    end else if (push) begin
      push_cnt++;
      run++;
      check_eq("sb_nonempty", 64'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        word_t w;
        w = sb_q.pop_front();
        check_eq("push_data", push_data, w.data);
        check_eq("push_mask", 64'(push_mask), 64'(w.mask));
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int unsigned w;
    rst = 1'b1; valid_flush = 1'b0; in_data = '0; in_valid = 1'b0;
    in_last = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_push", push, 0);
    check_eq("rst_data", push_data, 0);
    check_eq("rst_mask", 64'(push_mask), 0);
    check_eq("rst_in_ready", in_ready, 1);
    step();

    // Full word, one-cycle latency
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b0);
    @(negedge clk);
    check_eq("lat_full", push, 1);
    step();

    // Early-closed word, then a full word proves idx restarted at 0
    send_beat(32'hC, 1'b1);
    @(negedge clk);
    check_eq("lat_last", push, 1);
    step();
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b0);
    step(); step();

    // Backpressure: held word stays put, then pushes once
    ready = 1'b0;
    send_beat(32'h5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_push", push, 0);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_data", push_data, 64'h5);
      check_eq("bp_mask", 64'(push_mask), 1);
      step();
    end
    c0 = push_cnt;
    ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release", push, 1);
    step(); step(); step(); step();
    check_eq("bp_push_once", 64'(push_cnt - c0), 1);

    // Back-to-back last beats
    send_beat(32'h1, 1'b1);
    send_beat(32'h2, 1'b1);
    send_beat(32'h3, 1'b1);
    step(); step(); step();
    check_eq("b2b_run", 64'(last_run), 3);

    // Flush discards the partial word and the beat offered alongside it
    send_beat(32'hD, 1'b0);
    do_flush(1'b1);
    send_beat(32'hE, 1'b0);
    send_beat(32'hF, 1'b0);
    step(); step();

    // Reset while a word is held under backpressure
    ready = 1'b0;
    send_beat(32'h7, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("rst_mid_push", push, 0);
    check_eq("rst_mid_mask", 64'(push_mask), 0);
    check_eq("rst_mid_data", push_data, 0);
    check_eq("rst_mid_in_ready", in_ready, 1);
    step();
    c0 = push_cnt;
    ready = 1'b1;
    repeat (4) step();
    check_eq("rst_no_push", 64'(push_cnt - c0), 0);

    w = 0;
    while (sb_q.size() != 0 && w < 20) begin
      step();
      w++;
    end
    check_eq("sb_drain", 64'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
